// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- parametrised multi-read-port register file
//
// General-purpose register file for the single-cycle CPU. It takes the read
// addresses from decode, one write port from the writeback mux, and a
// dedicated link port from the PC+4 path for jump-and-link.
//
// Register 0 is hard-wired to zero. After reset the file clears itself with
// a sweep that takes one clock per register. Busy is high during the sweep.
// While Busy is high, writes are ignored and every read port returns zero.
//
// Parameters
//   DATA_W   register width in bits
//   ADDR_W   address width; DEPTH = 2**ADDR_W entries
//   NUM_RD   number of independent read ports (1..4)
//   LINK_REG index written by the link port
//   BYPASS   1: reads see same-cycle writes; 0: reads see stored value only
//
// Ports
//   CLK        clock; all state updates on the rising edge
//   Reset      synchronous active-high reset; starts the clear sweep
//   ReadReg    packed read addresses; port k at [k*ADDR_W +: ADDR_W]
//   ReadData   packed read data;      port k at [k*DATA_W +: DATA_W]
//   RegWrite   main write enable
//   WriteReg   main write address
//   WriteData  main write data
//   LinkWrite  link write enable (JAL)
//   LinkData   link value (PC+4)
//   Busy       high while the clear sweep is in progress
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int LINK_REG = 31,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [NUM_RD*ADDR_W-1:0] ReadReg,
  output logic [NUM_RD*DATA_W-1:0] ReadData,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        WriteReg,
  input  logic [DATA_W-1:0]        WriteData,
  input  logic                     LinkWrite,
  input  logic [DATA_W-1:0]        LinkData,
  output logic                     Busy
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // The initial values give the power-up state: IDLE, not busy, and all
  // registers zero. FPGA flows load these values at configuration.
  state_t            stateReg = IDLE;
  state_t            stateNext;
  logic [ADDR_W-1:0] idxReg = FIRST_IDX;
  logic [ADDR_W-1:0] idxNext;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic clearEn;
  logic mainWrEn;
  logic linkWrEn;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    stateReg <= stateNext;
    idxReg   <= idxNext;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // The sweep starts at index 1 because entry 0 is never written. A reset
  // during the sweep pins the index back to 1, so the sweep restarts from
  // the beginning when reset is released.
  // -------------------------------------------------------------------------
  always_comb begin
    stateNext = stateReg;
    idxNext   = idxReg;
    if (Reset) begin
      stateNext = CLEAR;
      idxNext   = FIRST_IDX;
    end else begin
      unique case (stateReg)
        IDLE: begin
          stateNext = IDLE;
        end
        CLEAR: begin
          idxNext = idxReg + FIRST_IDX;
          if (idxReg == LAST_ADDR) begin
            stateNext = IDLE;
          end
        end
        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output / control decode
  // Reset has priority over any write in the same cycle. Busy comes straight
  // from the state register, so it is high on the cycle after the reset edge.
  // -------------------------------------------------------------------------
  always_comb begin
    Busy     = (stateReg == CLEAR);
    clearEn  = (stateReg == CLEAR) && !Reset;
    mainWrEn = (stateReg == IDLE) && !Reset && RegWrite && (WriteReg != '0);
    linkWrEn = (stateReg == IDLE) && !Reset && LinkWrite && (LINK_ADDR != '0);
  end

  // -------------------------------------------------------------------------
  // Storage
  // The link write comes after the main write, so it wins when both ports
  // target LINK_REG in the same cycle. The sweep index is never 0, so
  // entry 0 keeps its zero value.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (clearEn) begin
      mem[idxReg] <= '0;
    end else begin
      if (mainWrEn) begin
        mem[WriteReg] <= WriteData;
      end
      if (linkWrEn) begin
        mem[LINK_ADDR] <= LinkData;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read ports (combinational)
  // The bypass priority matches the write priority: link data, then main
  // write data, then the stored value. Address 0 returns 0 even when the
  // bypass is enabled.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : gRead
      logic [ADDR_W-1:0] rdAddr;
      logic [DATA_W-1:0] rdVal;

      assign rdAddr = ReadReg[gi*ADDR_W +: ADDR_W];

      always_comb begin
        rdVal = mem[rdAddr];
        if (Busy || (rdAddr == '0)) begin
          rdVal = '0;
        end else if (BYPASS && LinkWrite && (rdAddr == LINK_ADDR)) begin
          rdVal = LinkData;
        end else if (BYPASS && RegWrite && (rdAddr == WriteReg)) begin
          rdVal = WriteData;
        end
      end

      assign ReadData[gi*DATA_W +: DATA_W] = rdVal;
    end
  endgenerate

endmodule
